// File: rtl/dmem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp_pkg
// Description : Shared widths, FSM state encoding and address helpers for the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_resp_pkg;

    localparam int MemBusW     = 32;
    localparam int MemAddrBusW = 32;
    localparam int MemUnitW    = 4;

    typedef logic [MemBusW-1:0]     mem_bus_t;
    typedef logic [MemAddrBusW-1:0] mem_addr_t;
    typedef logic [MemUnitW-1:0]    mem_unit_t;

    typedef enum logic [1:0] {
        DmemIdle = 2'd0,
        DmemWait = 2'd1,
        DmemResp = 2'd2
    } dmem_state_e;

    localparam int DmemMaxWait = 15;
    localparam int WaitCntW    = $clog2(DmemMaxWait + 1);

    // Any set bit above the word-index field puts the address outside the RAM.
    function automatic logic addr_out_of_range(input mem_addr_t addr, input int idx_w);
        mem_addr_t hi;
        hi = addr >> (idx_w + 2);
        return hi != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp_if
// Description : Load/store request bus between the core and the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_resp_if;
    import dmem_resp_pkg::*;

    logic      cs_i;
    logic      we_i;
    mem_unit_t wem_i;
    mem_bus_t  din_i;
    mem_addr_t addr_i;
    logic      ready_o;
    mem_bus_t  rdata_o;
    logic      rvalid_o;
    logic      wdone_o;
    logic      err_o;

    modport master (
        output cs_i, we_i, wem_i, din_i, addr_i,
        input  ready_o, rdata_o, rvalid_o, wdone_o, err_o
    );

    modport slave (
        input  cs_i, we_i, wem_i, din_i, addr_i,
        output ready_o, rdata_o, rvalid_o, wdone_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Four-lane byte RAM, synchronous per-lane write and registered
//               read with enable, shaped for FPGA block RAM inference.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we_i,
    input  mem_unit_t        be_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] addr_i,
    input  mem_bus_t         wdata_i,
    output mem_bus_t         rdata_o
);

    generate
        for (genvar lane = 0; lane < MemUnitW; lane++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_q;

            // The read register only moves on read enable so the output holds.
            always_ff @(posedge clk) begin
                if (we_i && be_i[lane]) begin
                    mem[addr_i] <= wdata_i[8*lane +: 8];
                end
                if (re_i) begin
                    rd_q <= mem[addr_i];
                end
            end

            assign rdata_o[8*lane +: 8] = rd_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp
// Description : Data-memory responder: accepts core load/store requests,
//               optional wait states, byte-masked writes, registered reads.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rstn,
    dmem_resp_if.slave  bus
);

    localparam int                  IdxW     = $clog2(DEPTH_WORDS);
    localparam bit                  NoWait   = (WAIT_CYCLES == 0);
    localparam logic [WaitCntW-1:0] WaitLoad = WaitCntW'(WAIT_CYCLES);

    dmem_state_e         state_q, state_d;
    logic [WaitCntW-1:0] cnt_q,   cnt_d;
    logic                we_q,    we_d;
    mem_unit_t           wem_q,   wem_d;
    mem_bus_t            din_q,   din_d;
    logic [IdxW-1:0]     idx_q,   idx_d;
    logic                err_q,   err_d;
    logic                rd_zero_q, rd_zero_d;

    logic            ready;
    logic            accept;
    logic [IdxW-1:0] in_idx;
    logic            in_err;

    logic            cmt_en;
    logic            cmt_we;
    mem_unit_t       cmt_wem;
    mem_bus_t        cmt_din;
    logic [IdxW-1:0] cmt_idx;
    logic            cmt_err;

    logic            ram_we;
    logic            ram_re;
    mem_bus_t        ram_rdata;

    assign ready  = (state_q != DmemWait);
    assign accept = bus.cs_i && ready;
    assign in_idx = bus.addr_i[IdxW+1:2];
    assign in_err = addr_out_of_range(bus.addr_i, IdxW);

    // Without wait states the RAM is accessed on the accept edge straight from
    // the bus; otherwise from the latched request on the last WAIT edge.
    assign cmt_en  = NoWait ? accept : ((state_q == DmemWait) && (cnt_q == WaitCntW'(1)));
    assign cmt_we  = NoWait ? bus.we_i  : we_q;
    assign cmt_wem = NoWait ? bus.wem_i : wem_q;
    assign cmt_din = NoWait ? bus.din_i : din_q;
    assign cmt_idx = NoWait ? in_idx    : idx_q;
    assign cmt_err = NoWait ? in_err    : err_q;

    assign ram_we = cmt_en &&  cmt_we && !cmt_err && !rstn;
    assign ram_re = cmt_en && !cmt_we && !rstn;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        wem_d     = wem_q;
        din_d     = din_q;
        idx_d     = idx_q;
        err_d     = err_q;
        rd_zero_d = rd_zero_q;

        case (state_q)
            DmemIdle, DmemResp: begin
                if (accept) begin
                    we_d  = bus.we_i;
                    wem_d = bus.wem_i;
                    din_d = bus.din_i;
                    idx_d = in_idx;
                    err_d = in_err;
                    if (NoWait) begin
                        state_d = DmemResp;
                    end else begin
                        state_d = DmemWait;
                        cnt_d   = WaitLoad;
                    end
                end else begin
                    state_d = DmemIdle;
                end
            end
            DmemWait: begin
                cnt_d = cnt_q - WaitCntW'(1);
                if (cnt_q == WaitCntW'(1)) begin
                    state_d = DmemResp;
                end
            end
            default: begin
                state_d = DmemIdle;
            end
        endcase

        // Out-of-range reads present zero until the next read lands.
        if (cmt_en && !cmt_we) begin
            rd_zero_d = cmt_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= DmemIdle;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            wem_q     <= '0;
            din_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            wem_q     <= wem_d;
            din_q     <= din_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IdxW)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .be_i    (cmt_wem),
        .re_i    (ram_re),
        .addr_i  (cmt_idx),
        .wdata_i (cmt_din),
        .rdata_o (ram_rdata)
    );

    assign bus.ready_o  = ready;
    assign bus.rdata_o  = rd_zero_q ? '0 : ram_rdata;
    assign bus.rvalid_o = (state_q == DmemResp) && !we_q;
    assign bus.wdone_o  = (state_q == DmemResp) &&  we_q;
    assign bus.err_o    = (state_q == DmemResp) &&  err_q;

endmodule
`default_nettype wire
